// File: rtl/bg_pixel_serializer.sv
// bg_pixel_serializer: double-buffered background line serializer.
// A finished line (4 colour planes + enable/priority/palette masks) is held
// in a shadow bank. It is swapped into the active bank on pixStart and then
// streamed one pixel per pixStep. Each pixel is looked up in a synchronous
// CRAM, so the colour and flags come out with a fixed 3-cycle latency.
// Optional feature macro: VDP_LEFT_BLANK_EN (adds leftBlank/backdropIdx;
// pixels 0..7 then come from the backdrop palette entry).
// Ports:
//   clk, rst           clock; synchronous active-high reset
//   patOut0..3         background colour planes, bit LINE_W-1-x = pixel x
//   patEn              1 = opaque background pixel
//   patPriority        1 = background pixel drawn in front of sprites
//   patPalette         1 = use the upper 16 CRAM entries
//   ready              pulse: load all planes into the shadow bank
//   pixStart           pulse: swap shadow into active, restart at x=0
//   pixStep            pixel enable while streaming
//   cramAddr/cramOut   CRAM read port (read data arrives 1 cycle later)
//   pixColor           output pixel colour
//   pixValid           output pixel is valid this cycle
//   pixBgPriority      priority flag of the output pixel
//   pixBgOpaque        enable flag of the output pixel
//   lineDone           pulse with the last pixel of a completed line
//   underrun           pulse: pixStart found no fresh shadow line
`timescale 1ns/1ps
module bg_pixel_serializer #(
   parameter int LINE_W  = 256,
   parameter int CRAM_AW = 5,
   parameter int COLOR_W = 6
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [LINE_W-1:0]  patOut0,
   input  logic [LINE_W-1:0]  patOut1,
   input  logic [LINE_W-1:0]  patOut2,
   input  logic [LINE_W-1:0]  patOut3,
   input  logic [LINE_W-1:0]  patEn,
   input  logic [LINE_W-1:0]  patPriority,
   input  logic [LINE_W-1:0]  patPalette,
   input  logic               ready,
   input  logic               pixStart,
   input  logic               pixStep,
`ifdef VDP_LEFT_BLANK_EN
   input  logic               leftBlank,
   input  logic [3:0]         backdropIdx,
`endif
   output logic [CRAM_AW-1:0] cramAddr,
   input  logic [COLOR_W-1:0] cramOut,
   output logic [COLOR_W-1:0] pixColor,
   output logic               pixValid,
   output logic               pixBgPriority,
   output logic               pixBgOpaque,
   output logic               lineDone,
   output logic               underrun
);

   localparam int XW = $clog2(LINE_W);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t state, state_nx;

   // Bank rows: 0..3 colour planes, 4 enable, 5 priority, 6 palette.
   logic [6:0][LINE_W-1:0] sh;
   logic [6:0][LINE_W-1:0] act;
   logic                   fresh;

   logic [XW-1:0]      x;
   logic [XW-1:0]      b;
   logic               last_x;
   logic               step_acc;
   logic               dcnt;
   logic [CRAM_AW-1:0] addr_nx;
   logic               pri_nx;
   logic               opq_nx;

   logic s1_v, s1_pri, s1_opq, s1_last;
   logic s2_v, s2_pri, s2_opq, s2_last;

   assign last_x = (x == XW'(LINE_W-1));

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Next state; pixStart restarts the line from any state
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (pixStart) state_nx = RUN;
         RUN: begin
            if (pixStart)              state_nx = RUN;
            else if (step_acc && last_x) state_nx = DRAIN;
         end
         DRAIN: begin
            if (pixStart)  state_nx = RUN;
            else if (dcnt) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // FSM outputs; a step coinciding with pixStart belongs to no line
   always_comb begin
      step_acc = 1'b0;
      unique case (state)
         RUN:     step_acc = pixStep & ~pixStart;
         default: step_acc = 1'b0;
      endcase
   end

   // Two-cycle drain timer
   always_ff @(posedge clk) begin
      if (rst) dcnt <= 1'b0;
      else     dcnt <= (state == DRAIN) & ~pixStart & ~dcnt;
   end

   always_ff @(posedge clk) begin
      if (rst)
         x <= '0;
      else if (pixStart)
         x <= '0;
      else if (step_acc && !last_x)
         x <= x + 1'b1;
   end

   // Swap reads the shadow as held before this edge, so a same-cycle
   // ready replays the old line and leaves the new one marked fresh.
   always_ff @(posedge clk) begin
      if (rst) begin
         sh    <= '0;
         act   <= '0;
         fresh <= 1'b0;
      end else begin
         if (pixStart) act <= sh;
         if (ready)
            sh <= {patPalette, patPriority, patEn,
                   patOut3, patOut2, patOut1, patOut0};
         if (ready)         fresh <= 1'b1;
         else if (pixStart) fresh <= 1'b0;
      end
   end

   always_comb begin
      b       = XW'(LINE_W-1) - x;
      addr_nx = CRAM_AW'({act[6][b], act[3][b], act[2][b],
                          act[1][b], act[0][b]});
      pri_nx  = act[5][b];
      opq_nx  = act[4][b];
`ifdef VDP_LEFT_BLANK_EN
      if (leftBlank && (x < XW'(8))) begin
         addr_nx = CRAM_AW'({1'b1, backdropIdx});
         pri_nx  = 1'b0;
         opq_nx  = 1'b0;
      end
`endif
   end

   // Address stage, CRAM wait stage, output stage
   always_ff @(posedge clk) begin
      if (rst) begin
         cramAddr      <= '0;
         s1_v          <= 1'b0;
         s1_pri        <= 1'b0;
         s1_opq        <= 1'b0;
         s1_last       <= 1'b0;
         s2_v          <= 1'b0;
         s2_pri        <= 1'b0;
         s2_opq        <= 1'b0;
         s2_last       <= 1'b0;
         pixColor      <= '0;
         pixValid      <= 1'b0;
         pixBgPriority <= 1'b0;
         pixBgOpaque   <= 1'b0;
         lineDone      <= 1'b0;
         underrun      <= 1'b0;
      end else begin
         if (step_acc) begin
            cramAddr <= addr_nx;
            s1_pri   <= pri_nx;
            s1_opq   <= opq_nx;
         end
         s1_v    <= step_acc;
         s1_last <= step_acc & last_x;
         s2_v    <= s1_v;
         s2_pri  <= s1_pri;
         s2_opq  <= s1_opq;
         s2_last <= s1_last;
         if (s2_v) begin
            pixColor      <= cramOut;
            pixBgPriority <= s2_pri;
            pixBgOpaque   <= s2_opq;
         end
         pixValid <= s2_v;
         lineDone <= s2_v & s2_last;
         underrun <= pixStart & ~fresh;
      end
   end

endmodule
